// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle W-bit add/subtract, one 4-bit carry-lookahead
// nibble per clock, valid/ready on both sides, NZCV-style flags.
//
// state | meaning
// IDLE  | waiting for a request (in_ready high once out of reset)
// BUSY  | processing nibble r_idx, carry chained through r_carry
// DONE  | result and flags valid, waiting for out_ready
module seq_addsub #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int NIB = W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_init;
  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_zero;
  logic          r_neg;
  logic          r_ovf;

  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [3:0]    w_x;
  logic [3:0]    w_y;
  logic [3:0]    w_p;
  logic [3:0]    w_g;
  logic [4:0]    w_c;
  logic [3:0]    w_sum;
  logic [W-1:0]  w_res_next;

  // Blocks acceptance until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = r_init;
        if (r_init && in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (r_idx == LAST_IDX) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && r_init && in_valid;
  assign w_step   = (r_state == BUSY);
  assign w_last   = w_step && (r_idx == LAST_IDX);

  // 4-bit carry-lookahead slice on the current nibble; carries are flat
  // sum-of-products so no carry ripples inside the slice.
  always_comb begin
    w_x   = r_opa[4*r_idx +: 4];
    w_y   = r_opb[4*r_idx +: 4];
    w_p   = w_x ^ w_y;
    w_g   = w_x & w_y;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_sum = w_p ^ w_c[3:0];
    w_res_next = r_result;
    w_res_next[4*r_idx +: 4] = w_sum;
  end

  // Operand capture, per-nibble accumulation and flag registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_opa    <= a;
      r_opb    <= op ? ~b : b;
      r_carry  <= op;
      r_idx    <= '0;
      r_result <= '0;
    end else if (w_step) begin
      r_result <= w_res_next;
      r_carry  <= w_c[4];
      r_idx    <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c[4];
        r_zero <= (w_res_next == '0);
        r_neg  <= w_res_next[W-1];
        r_ovf  <= (r_opa[W-1] == r_opb[W-1]) && (w_res_next[W-1] != r_opa[W-1]);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Multi-cycle 32-bit add/subtract unit for the datapath. It is the subtract-direction companion to the existing combinational adders. It computes a + b or a - b one 4-bit carry-lookahead nibble per clock, using the a + ~b + 1 form for subtraction. A valid/ready handshake sits on each side, and the result is returned with NZCV-style flags, so the ALU can share one narrow slice instead of a full 32-bit ripple chain.

Parameters:
- W, 32, operand/result width; must be a multiple of 4.
- NIB, W/4, number of nibble steps (derived; not to be overridden).

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- in_valid  in  1  Request present on a, b, op.
- in_ready  out  1  Unit can accept a request.
- a  in  W  Minuend / first addend.
- b  in  W  Subtrahend / second addend.
- op  in  1  0 = add (a + b); 1 = subtract (a - b).
- out_valid  out  1  Result and flags valid.
- out_ready  in  1  Consumer takes result.
- result  out  W  Sum or difference, modulo 2^W.
- cout  out  1  Raw carry out of bit W-1. For subtract: 1 = no borrow (a >= b unsigned), 0 = borrow.
- zero  out  1  result == 0.
- neg  out  1  result[W-1].
- ovf  out  1  Signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - in_ready = 0 while rst_n is low; 1 from the first clk edge after release.
  - out_valid = 0; result = 0; cout = 0; zero = 0; neg = 0; ovf = 0.
  - Nibble index and carry cleared.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1:
    - latch a into opa;
    - latch op ? ~b : b into opb;
    - set carry = op;
    - clear the result accumulator;
    - set idx = 0;
    - go to BUSY.
  - in_valid = 0: stay in IDLE.
- BUSY:
  - in_ready = 0.
  - Each edge, evaluate 4-bit CLA on opa[4idx+3:4idx], opb[4idx+3:4idx] and carry:
    - p = x ^ y; g = x & y;
    - internal carries use lookahead equations, not a ripple chain;
    - write the 4 sum bits into result bits [4idx+3:4idx];
    - carry = nibble carry-out;
    - idx increments.
  - On the edge processing idx = NIB-1, go to DONE and register the flags:
    - cout = final carry;
    - zero = (full result == 0);
    - neg = result[W-1];
    - ovf = (opa[W-1] == opb[W-1]) && (result[W-1] != opa[W-1]), using the inverted b for subtract.
- Latency: the accept edge is cycle 0. out_valid rises after edge NIB (8 for W = 32). It is exact and data-independent.
- DONE:
  - out_valid = 1; in_ready = 0.
  - result and flags are held stable until handshake.
  - On an edge with out_ready = 1: out_valid = 0, go to IDLE. in_ready is 1 in the following cycle, so there is one bubble and no back-to-back overlap.
  - out_ready = 0: hold indefinitely.
- Inputs a, b and op are sampled only on the accept edge. Changes while in BUSY or DONE have no effect.
- in_valid while in BUSY or DONE is ignored. The requester must hold it until in_ready.
- out_ready outside DONE is ignored.
- result and flags between requests:
  - they keep the last completed values after the DONE handshake;
  - result bits are overwritten nibble-by-nibble during BUSY;
  - consumers read only when out_valid = 1.
- Reset mid-operation, in BUSY or DONE: immediate abort, all outputs to reset values, no partial result ever flagged valid.
- Arithmetic is modulo 2^W. There are no saturation or trap outputs.

Test Plan:
- Subtract, no borrow: op=1, a=0x0000000A, b=0x00000003 -> after 8 cycles out_valid=1, result=0x00000007, cout=1, zero=0, neg=0, ovf=0.
- Subtract, borrow: op=1, a=0x00000003, b=0x0000000A -> result=0xFFFFFFF9, cout=0, neg=1, ovf=0.
- Signed overflow: op=1, a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, cout=1, ovf=1, neg=0.
- Add with full carry propagation, then equal subtract:
  - op=0, a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, zero=1, cout=1, ovf=0.
  - op=1, a=b=0x12345678 -> result=0, zero=1, cout=1.
- Backpressure and input stability:
  - hold out_ready=0 for 5 cycles after out_valid, toggling a/b/in_valid meanwhile -> result and flags unchanged, in_ready=0 throughout;
  - out_ready=1 -> out_valid drops next edge, in_ready=1 the cycle after.
- Reset mid-op: assert rst_n=0 at BUSY idx=4 -> out_valid=0 and in_ready=0 immediately, without a clock edge. After release, a new request 0x5-0x5 completes in exactly 8 cycles with zero=1.
